// File: rtl/mask_pkg.sv
// Shared types and sine-table helpers for the modulator family (ASK now, PSK/QAM later).
package mask_pkg;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic int lut_peak(input int sample_w);
    return (1 << (sample_w - 2)) - 1;
  endfunction

  // Sine sample for table address a, rounded half away from zero.
  function automatic int lut_entry(input int lut_aw, input int sample_w, input int a);
    real ph;
    real v;
    ph = 2.0 * 3.14159265358979323846 * real'(a) / real'(1 << lut_aw);
    v  = real'(lut_peak(sample_w)) * $sin(ph);
    if (v >= 0.0) begin
      return $rtoi(v + 0.5);
    end
    return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/mask_modulator_if.sv
// Symbol stream handshake between the symbol source and the modulator.
interface mask_modulator_if #(
  parameter int unsigned BITS_PER_SYM = 2
);
  logic [BITS_PER_SYM-1:0] sym_data;
  logic                    sym_valid;
  logic                    sym_ready;

  modport master (output sym_data, output sym_valid, input sym_ready);
  modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/sine_lut.sv
// Full-wave sine table with a registered output (1-cycle latency).
module sine_lut #(
  parameter int unsigned LUT_AW   = 8,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [LUT_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] data
);
  import mask_pkg::*;

  localparam int unsigned Depth = 1 << LUT_AW;

  logic signed [SAMPLE_W-1:0] rom [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_rom
    assign rom[i] = SAMPLE_W'(lut_entry(LUT_AW, SAMPLE_W, i));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data <= '0;
    end else begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/mask_modulator.sv
// M-ary ASK modulator: DDS carrier scaled per symbol to one of 2^BITS_PER_SYM amplitude levels.
module mask_modulator #(
  parameter int unsigned PHASE_W      = 32,
  parameter int unsigned LUT_AW       = 8,
  parameter int unsigned SAMPLE_W     = 16,
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned SYM_LEN_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PHASE_W-1:0]         increment,
  input  logic [LUT_AW-1:0]          phase_offset,
  input  logic [SYM_LEN_W-1:0]       samples_per_sym,
  input  logic                       enable,
  mask_modulator_if.slave            sym,
  input  logic                       clear_underrun,
  output logic signed [SAMPLE_W-1:0] carrier,
  output logic signed [SAMPLE_W-1:0] ask_out,
  output logic                       sym_strobe,
  output logic                       underrun
);
  import mask_pkg::*;

  localparam int unsigned ProdW = SAMPLE_W + BITS_PER_SYM + 1;

  logic [PHASE_W-1:0]      acc_q;
  logic [LUT_AW-1:0]       lut_addr;
  state_e                  state_q, state_d;
  logic [SYM_LEN_W-1:0]    cnt_q, cnt_d, sym_len_m1;
  logic [BITS_PER_SYM-1:0] level_q, level_d, level_dly_q;
  logic                    strobe_d, underrun_d;
  logic                    cnt_zero, handshake;
  logic signed [ProdW-1:0] product;

  // Phase accumulator free-runs regardless of symbol activity.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_q + increment;
    end
  end

  assign lut_addr = acc_q[PHASE_W-1 -: LUT_AW] + phase_offset;

  sine_lut #(
    .LUT_AW   (LUT_AW),
    .SAMPLE_W (SAMPLE_W)
  ) u_sine_lut (
    .clock (clock),
    .reset (reset),
    .addr  (lut_addr),
    .data  (carrier)
  );

  assign cnt_zero      = (cnt_q == '0);
  assign sym_len_m1    = (samples_per_sym == '0) ? '0 : samples_per_sym - SYM_LEN_W'(1);
  assign sym.sym_ready = !reset && enable && ((state_q == StIdle) || cnt_zero);
  assign handshake     = sym.sym_ready && sym.sym_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    strobe_d   = 1'b0;
    underrun_d = underrun && !clear_underrun;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          level_d  = sym.sym_data;
          cnt_d    = sym_len_m1;
          strobe_d = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - SYM_LEN_W'(1);
        end else if (handshake) begin
          level_d  = sym.sym_data;
          cnt_d    = sym_len_m1;
          strobe_d = 1'b1;
        end else if (enable) begin
          // Starved: transmit a full-length silent symbol and flag it.
          level_d    = '0;
          cnt_d      = sym_len_m1;
          underrun_d = 1'b1;
        end else begin
          level_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      sym_strobe  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;  // aligns the level with the LUT output stage
      sym_strobe  <= strobe_d;
      underrun    <= underrun_d;
    end
  end

  assign product = ProdW'(carrier) * ProdW'($signed({1'b0, level_dly_q}));

  always_ff @(posedge clock) begin
    if (reset) begin
      ask_out <= '0;
    end else begin
      ask_out <= SAMPLE_W'(product >>> BITS_PER_SYM);
    end
  end

endmodule

// File: tb/tb_mask_modulator.sv
// Self-checking bench for mask_modulator against a sample-level behavioural model.
module tb_mask_modulator;

  localparam int unsigned PHASE_W      = 32;
  localparam int unsigned LUT_AW       = 8;
  localparam int unsigned SAMPLE_W     = 16;
  localparam int unsigned BITS_PER_SYM = 2;
  localparam int unsigned SYM_LEN_W    = 16;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic [PHASE_W-1:0]         increment = '0;
  logic [LUT_AW-1:0]          phase_offset = '0;
  logic [SYM_LEN_W-1:0]       samples_per_sym = 16'd1;
  logic                       enable = 1'b0;
  logic                       clear_underrun = 1'b0;
  logic signed [SAMPLE_W-1:0] carrier;
  logic signed [SAMPLE_W-1:0] ask_out;
  logic                       sym_strobe;
  logic                       underrun;

  mask_modulator_if #(.BITS_PER_SYM(BITS_PER_SYM)) sym_bus ();

  mask_modulator #(
    .PHASE_W      (PHASE_W),
    .LUT_AW       (LUT_AW),
    .SAMPLE_W     (SAMPLE_W),
    .BITS_PER_SYM (BITS_PER_SYM),
    .SYM_LEN_W    (SYM_LEN_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .increment       (increment),
    .phase_offset    (phase_offset),
    .samples_per_sym (samples_per_sym),
    .enable          (enable),
    .sym             (sym_bus),
    .clear_underrun  (clear_underrun),
    .carrier         (carrier),
    .ask_out         (ask_out),
    .sym_strobe      (sym_strobe),
    .underrun        (underrun)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Reference model: one entry per transmitted sample, pipelined to the outputs.
  longint unsigned m_acc;
  int m_carrier, m_ask, m_lvl_c, m_lvl_s;
  int m_lvl, m_pos, m_len;
  bit m_running, m_underrun, m_strobe, m_hs;

  function automatic int lut_ref(input int a);
    real v;
    v = 16383.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 256.0);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  function automatic int floor4(input int p);
    int q;
    q = p / 4;
    if ((p % 4) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic bit ready_model();
    return !reset && enable && (!m_running || (m_pos == m_len - 1));
  endfunction

  function automatic logic [34:0] expected();
    return {m_carrier[15:0], m_ask[15:0], m_strobe, m_underrun, ready_model()};
  endfunction

  task automatic model_step();
    bit set_ur;
    int addr;
    int len;
    if (reset) begin
      m_acc = 0; m_carrier = 0; m_ask = 0; m_lvl_c = 0; m_lvl_s = 0;
      m_lvl = 0; m_pos = 0; m_len = 1; m_running = 0;
      m_underrun = 0; m_strobe = 0; m_hs = 0;
    end else begin
      set_ur = 0;
      len    = (samples_per_sym == 0) ? 1 : int'(samples_per_sym);
      m_hs   = ready_model() && sym_bus.sym_valid;
      m_ask  = floor4(m_carrier * m_lvl_c);
      addr   = (int'(m_acc >> (PHASE_W - LUT_AW)) + int'(phase_offset)) % 256;
      m_carrier = lut_ref(addr);
      m_lvl_c   = m_lvl_s;
      if (m_running && m_pos < m_len - 1) begin
        m_pos++;
      end else if (m_hs) begin
        m_running = 1; m_pos = 0; m_len = len; m_lvl = int'(sym_bus.sym_data);
      end else if (m_running && enable) begin
        m_lvl = 0; m_pos = 0; m_len = len; set_ur = 1;
      end else begin
        m_lvl = 0; m_running = 0;
      end
      m_lvl_s    = m_lvl;
      m_strobe   = m_hs;
      m_underrun = set_ur ? 1'b1 : (clear_underrun ? 1'b0 : m_underrun);
      m_acc      = (m_acc + longint'(increment)) & 64'hffff_ffff;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; sym_bus.sym_valid = 1'b1; sym_bus.sym_data = 2'd3;
    increment = 32'h0123_4567; samples_per_sym = 16'd3; clear_underrun = 1'b0;
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      sym_bus.sym_valid = (i % 5) != 4;
      tick();
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== 35'd0)
        $display("FAIL reset cycle %0d: outputs %h, required 0", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready});
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  task automatic test_carrier();
    increment = 32'h0100_0000; phase_offset = '0; enable = 1'b0;
    sym_bus.sym_valid = 1'b0;
    do_reset(2);
    for (int i = 1; i <= 70; i++) begin
      tick();
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
        $display("FAIL carrier sample %0d: got %h, required %h", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
      else pass_cnt++;
      if (i == 2 || i == 65) begin
        check_cnt++;
        if (carrier !== ((i == 2) ? 16'h0192 : 16'h3fff))
          $display("FAIL carrier_const sample %0d: got %h", i, carrier);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_scaling();
    for (int k = 0; k < 2; k++) begin
      increment = '0; phase_offset = (k == 0) ? 8'h40 : 8'hc0;
      enable = 1'b1; sym_bus.sym_valid = 1'b1; sym_bus.sym_data = (k == 0) ? 2'd3 : 2'd2;
      samples_per_sym = 16'd100;
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
        tick();
        sym_bus.sym_valid = 1'b0;
        check_cnt++;
        if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
          $display("FAIL scaling%0d cycle %0d: got %h, required %h", k, i,
                   {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
        else pass_cnt++;
      end
      check_cnt++;
      if (ask_out !== ((k == 0) ? 16'h2fff : 16'he000))
        $display("FAIL scaling_const%0d: ask_out %h", k, ask_out);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int syms[4] = '{1, 2, 3, 0};
    int idx = 0;
    int last = -1;
    increment = 32'h0371_2e45; phase_offset = 8'h11; samples_per_sym = 16'd4;
    enable = 1'b1; sym_bus.sym_valid = 1'b1; sym_bus.sym_data = 2'(syms[0]);
    do_reset(1);
    for (int i = 0; i < 24; i++) begin
      tick();
      if (m_hs) begin
        idx++;
        sym_bus.sym_data = 2'(syms[idx % 4]);
      end
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
        $display("FAIL back_to_back cycle %0d: got %h, required %h", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
      else pass_cnt++;
      if (sym_strobe === 1'b1) begin
        if (last >= 0) begin
          check_cnt++;
          if (i - last !== 4) $display("FAIL strobe_gap cycle %0d: gap %0d, required 4", i, i - last);
          else pass_cnt++;
        end
        last = i;
      end
    end
  endtask

  task automatic test_underrun();
    increment = 32'h0100_0000; phase_offset = 8'h30; samples_per_sym = 16'd4;
    enable = 1'b1; sym_bus.sym_data = 2'd3; clear_underrun = 1'b0;
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      sym_bus.sym_valid = (i == 0) || (i >= 5 && i <= 8);
      clear_underrun    = (i == 12) || (i == 13);
      tick();
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
        $display("FAIL underrun cycle %0d: got %h, required %h", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
      else pass_cnt++;
      if (i >= 6 && i <= 9) begin
        check_cnt++;
        if (ask_out !== 16'h0000) $display("FAIL underrun_zero cycle %0d: ask_out %h", i, ask_out);
        else pass_cnt++;
      end
      if (i == 4 || i == 12) begin
        check_cnt++;
        if (underrun !== 1'b1) $display("FAIL underrun_sticky cycle %0d: underrun %b", i, underrun);
        else pass_cnt++;
      end
    end
    clear_underrun = 1'b0;
  endtask

  task automatic test_disable();
    increment = 32'h00c0_0000; phase_offset = 8'h20; samples_per_sym = 16'd5;
    enable = 1'b1; sym_bus.sym_valid = 1'b1; sym_bus.sym_data = 2'd2;
    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      enable = !(i >= 2 && i < 11);
      tick();
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
        $display("FAIL disable cycle %0d: got %h, required %h", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
      else pass_cnt++;
      if (i == 9) begin
        check_cnt++;
        if (ask_out !== 16'h0000) $display("FAIL disable_idle: ask_out %h", ask_out);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_zero_len();
    increment = 32'h0234_5678; samples_per_sym = '0;
    enable = 1'b1; sym_bus.sym_valid = 1'b1;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      sym_bus.sym_data = 2'($urandom_range(0, 3));
      tick();
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
        $display("FAIL zero_len cycle %0d: got %h, required %h", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
      else pass_cnt++;
      check_cnt++;
      if (sym_bus.sym_ready !== 1'b1) $display("FAIL zero_len_ready cycle %0d: sym_ready %b", i,
                                               sym_bus.sym_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      enable            = ($urandom_range(0, 9) != 0);
      sym_bus.sym_valid = ($urandom_range(0, 3) != 0);
      sym_bus.sym_data  = 2'($urandom_range(0, 3));
      samples_per_sym   = 16'($urandom_range(0, 3));
      clear_underrun    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) increment = $urandom();
      if ($urandom_range(0, 15) == 0) phase_offset = 8'($urandom_range(0, 255));
      tick();
      check_cnt++;
      if ({carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready} !== expected())
        $display("FAIL random cycle %0d: got %h, required %h", i,
                 {carrier, ask_out, sym_strobe, underrun, sym_bus.sym_ready}, expected());
      else pass_cnt++;
    end
  endtask

  initial begin
    sym_bus.sym_data  = '0;
    sym_bus.sym_valid = 1'b0;
    test_reset();
    test_carrier();
    test_scaling();
    test_back_to_back();
    test_underrun();
    test_disable();
    test_zero_len();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
